cmp_iter_n: RTL and testbench

CMP_ITER_N -- requirements
Module: cmp_iter_n

---
 rtl/cmp_iter_n_if.sv | 31 +++
 rtl/cmp_iter_n.sv | 105 ++++++++++
 tb/tb_cmp_iter_n.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_iter_n_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cmp_iter_n_if : request/result bundle for the iterative comparator (rev 1.0)
// ----------------------------------------------------------------------------
interface cmp_iter_n_if #(
  parameter int N  = 16,
  parameter int SW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          is_signed;
  logic          out_valid;
  logic          out_ready;
  logic          eq;
  logic          lt;
  logic          gt;
  logic [SW-1:0] out_steps;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, eq, lt, gt, out_steps
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, eq, lt, gt, out_steps
  );
endinterface
`default_nettype wire

// File: rtl/cmp_iter_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cmp_iter_n : chunked MSB-first magnitude comparator with early exit (rev 1.0)
// ----------------------------------------------------------------------------
module cmp_iter_n #(
  parameter int N = 16,
  parameter int C = 4
) (
  input  logic         clk,
  input  logic         reset,
  cmp_iter_n_if.slave  bus
);

  localparam int NCHUNK = N / C;
  localparam int SW     = $clog2(NCHUNK + 1);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((C < 1) || (C > N) || ((N % C) != 0)) begin : g_param_check
    $error("cmp_iter_n: N must be a non-zero multiple of C");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  a_q, b_q;
  logic [IW-1:0] idx_q;
  logic [SW-1:0] steps_q, steps_d;
  logic          eq_q, lt_q, gt_q;

  logic [N-1:0]  w_flip;
  logic [N-1:0]  w_a_sh, w_b_sh;
  logic [C-1:0]  w_a_chunk, w_b_chunk;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    w_flip        = '0;
    w_flip[N-1]   = bus.is_signed;
  end

  assign w_a_sh    = a_q >> (32'(idx_q) * C);
  assign w_b_sh    = b_q >> (32'(idx_q) * C);
  assign w_a_chunk = w_a_sh[C-1:0];
  assign w_b_chunk = w_b_sh[C-1:0];
  assign steps_d   = steps_q + SW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      steps_q <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a ^ w_flip;
            b_q     <= bus.b ^ w_flip;
            idx_q   <= IW'(NCHUNK - 1);
            steps_q <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          steps_q <= steps_d;
          if (w_a_chunk != w_b_chunk) begin
            eq_q    <= 1'b0;
            lt_q    <= (w_a_chunk < w_b_chunk);
            gt_q    <= (w_a_chunk > w_b_chunk);
            state_q <= DONE;
          end else if (idx_q == '0) begin
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q - IW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.eq        = eq_q;
  assign bus.lt        = lt_q;
  assign bus.gt        = gt_q;
  assign bus.out_steps = steps_q;

endmodule
`default_nettype wire

// File: tb/tb_cmp_iter_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cmp_iter_n : randomized and directed checks against a comparison model
// ----------------------------------------------------------------------------
module tb_cmp_iter_n;

  localparam int N   = 16;
  localparam int C   = 4;
  localparam int NCH = N / C;
  localparam int SW  = $clog2(NCH + 1);

  logic clk = 1'b0;
  logic reset;
  logic reset4;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cmp_iter_n_if #(.N(N), .SW(SW)) bus16 ();
  cmp_iter_n_if #(.N(4), .SW(1))  bus4 ();

  cmp_iter_n #(.N(N), .C(C)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  cmp_iter_n #(.N(4), .C(4)) u_dut4 (
    .clk   (clk),
    .reset (reset4),
    .bus   (bus4)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // rel: 0 equal, 1 less, 2 greater; steps = chunks scanned from the MSB end
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic s, input int w, input int cw,
                                output int rel, output int steps);
    longint va, vb;
    logic [N-1:0] diff;
    va = 0;
    vb = 0;
    for (int i = 0; i < w; i++) begin
      va += longint'(a[i]) << i;
      vb += longint'(b[i]) << i;
    end
    if (s) begin
      if (a[w-1]) va -= longint'(1) << w;
      if (b[w-1]) vb -= longint'(1) << w;
    end
    rel = (va == vb) ? 0 : ((va < vb) ? 1 : 2);
    diff  = a ^ b;
    steps = w / cw;
    for (int i = w / cw - 1; i >= 0; i--) begin
      if (((diff >> (i * cw)) & ((N'(1) << cw) - N'(1))) != '0) begin
        steps = w / cw - i;
        break;
      end
    end
  endfunction

  task automatic run16(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       input int bp, input bit noise);
    int rel, st, lat;
    model(a, b, s, N, C, rel, st);
    @(negedge clk);
    check("in_ready_idle", 32'(bus16.in_ready), 1);
    bus16.in_valid  = 1'b1;
    bus16.a         = a;
    bus16.b         = b;
    bus16.is_signed = s;
    bus16.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    lat = 0;
    while (!bus16.out_valid && lat <= NCH + 2) begin
      if (noise) begin
        bus16.in_valid  = 1'($urandom);
        bus16.a         = N'($urandom);
        bus16.b         = N'($urandom);
        bus16.is_signed = 1'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("out_valid", 32'(bus16.out_valid), 1);
    check("latency", lat, st);
    check("eq", 32'(bus16.eq), (rel == 0) ? 1 : 0);
    check("lt", 32'(bus16.lt), (rel == 1) ? 1 : 0);
    check("gt", 32'(bus16.gt), (rel == 2) ? 1 : 0);
    check("steps", 32'(bus16.out_steps), st);
    for (int i = 0; i < bp; i++) begin
      bus16.in_valid  = 1'($urandom);
      bus16.a         = N'($urandom);
      bus16.b         = N'($urandom);
      bus16.is_signed = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", 32'(bus16.out_valid), 1);
      check("bp_in_ready", 32'(bus16.in_ready), 0);
      check("bp_result", {29'd0, bus16.eq, bus16.lt, bus16.gt},
            (rel == 0) ? 4 : ((rel == 1) ? 2 : 1));
      check("bp_steps", 32'(bus16.out_steps), st);
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.out_ready = 1'b0;
    check("release_valid", 32'(bus16.out_valid), 0);
    check("release_ready", 32'(bus16.in_ready), 1);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int rel, st, lat;
    model(N'(a), N'(b), s, 4, 4, rel, st);
    @(negedge clk);
    bus4.in_valid  = 1'b1;
    bus4.a         = a;
    bus4.b         = b;
    bus4.is_signed = s;
    bus4.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    lat = 0;
    while (!bus4.out_valid && lat <= 3) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("n4_latency", lat, 1);
    check("n4_steps", 32'(bus4.out_steps), st);
    check("n4_result", {29'd0, bus4.eq, bus4.lt, bus4.gt},
          (rel == 0) ? 4 : ((rel == 1) ? 2 : 1));
    bus4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.out_ready = 1'b0;
    check("n4_release", 32'(bus4.in_ready), 1);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    bit           seen;
    reset  = 1'b1;
    reset4 = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0;
    bus16.is_signed = 1'b0; bus16.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0;
    bus4.is_signed = 1'b0; bus4.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus16.in_ready), 1);
    check("rst_out_valid", 32'(bus16.out_valid), 0);
    check("rst_flags", {29'd0, bus16.eq, bus16.lt, bus16.gt}, 0);
    check("rst_steps", 32'(bus16.out_steps), 0);
    check("rst4_in_ready", 32'(bus4.in_ready), 1);
    reset  = 1'b0;
    reset4 = 1'b0;

    run16(16'h1234, 16'h1234, 1'b0, 0, 1'b0);
    run16(16'h8000, 16'h7FFF, 1'b0, 0, 1'b0);
    run16(16'h8000, 16'h7FFF, 1'b1, 0, 1'b0);
    run16(16'h12A4, 16'h12B4, 1'b0, 0, 1'b0);
    run16(16'hABCD, 16'hABC0, 1'b0, 5, 1'b1);
    run16(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
    run4(4'h3, 4'h5, 1'b0);

    // Abort an equal-operand request during its second busy cycle
    @(negedge clk);
    bus16.in_valid = 1'b1; bus16.a = 16'h5555; bus16.b = 16'h5555; bus16.is_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", 32'(bus16.in_ready), 1);
    check("abort_flags", {29'd0, bus16.eq, bus16.lt, bus16.gt}, 0);
    check("abort_steps", 32'(bus16.out_steps), 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus16.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_result", 32'(seen), 0);

    for (int t = 0; t < 150; t++) begin
      ra = N'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = N'($urandom);
        default: rb = ra ^ (N'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
      endcase
      run16(ra, rb, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end
    for (int t = 0; t < 20; t++) begin
      run4(4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
